// File: rtl/tone_sequencer.sv
// tone_sequencer: steps a phase accumulator through a programmed note table
// once per codec frame and presents the top six accumulator bits as the sine
// table index.
// Optional feature: define TONE_SEQ_GAP_EN to insert GAP_FRAMES muted frames
// between consecutive notes, including the loop wrap.
module tone_sequencer #(
  parameter int NOTES      = 16,
  parameter int PHASE_W    = 16,
  parameter int DUR_W      = 16,
  parameter int GAP_FRAMES = 4
) (
  input  logic                     clock_24M,
  input  logic                     reset_n,
  input  logic                     ready,
  input  logic                     cfg_we,
  input  logic [$clog2(NOTES)-1:0] cfg_addr,
  input  logic [PHASE_W-1:0]       cfg_phase_inc,
  input  logic [DUR_W-1:0]         cfg_duration,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic [5:0]               sample_index,
  output logic                     sample_valid,
  output logic                     mute
);

  localparam int AW = $clog2(NOTES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NOTES - 1);

  if (PHASE_W < 6 || GAP_FRAMES < 1 || (1 << AW) != NOTES) begin : g_bad_params
    $error("tone_sequencer: invalid parameter set");
  end

`ifdef TONE_SEQ_GAP_EN
  localparam int GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

  logic [PHASE_W-1:0] inc_tbl [NOTES];
  logic [DUR_W-1:0]   dur_tbl [NOTES];

  state_t             state, state_n;
  logic [AW-1:0]      note_n;
  logic [PHASE_W-1:0] acc, acc_n;
  logic [PHASE_W-1:0] cur_inc, inc_n;
  logic [DUR_W-1:0]   frames_left, frames_n;
  logic               done_n, valid_n, mute_n, busy_n;
`ifdef TONE_SEQ_GAP_EN
  logic [GW-1:0]      gap_cnt, gap_n;
`endif

  assign sample_index = acc[PHASE_W-1 -: 6];

  // Note table: writable at any time; LOAD sees the pre-edge contents.
  always_ff @(posedge clock_24M) begin
    if (cfg_we) begin
      inc_tbl[cfg_addr] <= cfg_phase_inc;
      dur_tbl[cfg_addr] <= cfg_duration;
    end
  end

  // Next-state, datapath and output decode; stop overrides everything.
  always_comb begin
    state_n  = state;
    note_n   = note_idx;
    acc_n    = acc;
    inc_n    = cur_inc;
    frames_n = frames_left;
    done_n   = 1'b0;
    valid_n  = 1'b0;
`ifdef TONE_SEQ_GAP_EN
    gap_n    = gap_cnt;
`endif
    if (stop) begin
      state_n = IDLE;
      note_n  = '0;
      acc_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD;
            note_n  = '0;
          end
        end
        LOAD: begin
          if (dur_tbl[note_idx] != '0) begin
            frames_n = dur_tbl[note_idx];
            inc_n    = inc_tbl[note_idx];
            acc_n    = '0;
            state_n  = PLAY;
          end else if (loop_en && note_idx != '0) begin
            note_n = '0;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        PLAY: begin
          if (ready) begin
            acc_n    = acc + cur_inc;
            frames_n = frames_left - DUR_W'(1);
            valid_n  = 1'b1;
            if (frames_left == DUR_W'(1)) begin
              if (note_idx == LAST_IDX && !loop_en) begin
                done_n  = 1'b1;
                state_n = IDLE;
              end else begin
                // NOTES is a power of two, so LAST_IDX + 1 wraps to 0 for the loop.
                note_n = note_idx + AW'(1);
`ifdef TONE_SEQ_GAP_EN
                gap_n   = '0;
                state_n = GAP;
`else
                state_n = LOAD;
`endif
              end
            end
          end
        end
`ifdef TONE_SEQ_GAP_EN
        GAP: begin
          if (ready) begin
            valid_n = 1'b1;
            if (gap_cnt == GAP_LAST) state_n = LOAD;
            else                     gap_n   = gap_cnt + GW'(1);
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE);
    // LOAD keeps the previous mute so the last frame of a note is not cut.
    if (state_n == LOAD)      mute_n = mute;
    else if (state_n == PLAY) mute_n = (inc_n == '0);
    else                      mute_n = 1'b1;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock_24M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      note_idx     <= '0;
      acc          <= '0;
      cur_inc      <= '0;
      frames_left  <= '0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      mute         <= 1'b1;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      note_idx     <= note_n;
      acc          <= acc_n;
      cur_inc      <= inc_n;
      frames_left  <= frames_n;
      done         <= done_n;
      sample_valid <= valid_n;
      busy         <= busy_n;
      mute         <= mute_n;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt      <= gap_n;
`endif
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and randomized note sequences checked against a
// frame-level model of the note table walk.
module tb_tone_sequencer;

`ifdef TONE_SEQ_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif

  logic        clock_24M = 1'b0;
  logic        reset_n;
  logic        ready, cfg_we, start, stop, loop_en;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_phase_inc, cfg_duration;
  logic        busy, done, sample_valid, mute;
  logic [3:0]  note_idx;
  logic [5:0]  sample_index;

  tone_sequencer #(.NOTES(16), .PHASE_W(16), .DUR_W(16), .GAP_FRAMES(4)) dut (
    .clock_24M(clock_24M), .reset_n(reset_n), .ready(ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_phase_inc(cfg_phase_inc), .cfg_duration(cfg_duration),
    .start(start), .stop(stop), .loop_en(loop_en), .busy(busy), .done(done),
    .note_idx(note_idx), .sample_index(sample_index), .sample_valid(sample_valid),
    .mute(mute)
  );

  always #5 clock_24M = ~clock_24M;

  typedef struct {
    logic [5:0] idx;
    logic       mute;
    bit         mchk;
    logic [3:0] note;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] t_inc [16];
  logic [15:0] t_dur [16];
  int          n_asrt = 0;
  int          n_fail = 0;
  int          done_cnt;
  logic        fall_done;
  logic        prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_24M);
    #1;
    if (done === 1'b1) done_cnt++;
    if (prev_busy && !busy) fall_done = done;
    prev_busy = busy;
  endtask

  task automatic program_table();
    for (int a = 0; a < 16; a++) begin
      cfg_we = 1'b1; cfg_addr = 4'(a);
      cfg_phase_inc = t_inc[a]; cfg_duration = t_dur[a];
      step();
    end
    cfg_we = 1'b0;
  endtask

  // Walk the note table as a listener would hear it, one entry per frame.
  task automatic build_model(input bit lp, input int maxf, output bit exp_done);
    frame_t f;
    int i, nxt, guard;
    bit ending;
    int unsigned p;
    exp_q.delete();
    exp_done = 0; i = 0; guard = 0;
    while (exp_q.size() < maxf && guard < 200) begin
      guard++;
      if (t_dur[i] == 0) begin
        if (lp && i != 0) i = 0;
        else begin exp_done = 1; break; end
      end else begin
        ending = (i == 15) && !lp;
        nxt = (i + 1) % 16;
        for (int k = 1; k <= int'(t_dur[i]); k++) begin
          p = (k * int'(t_inc[i])) % 65536;
          f.idx  = 6'(p >> 10);
          f.mute = (t_inc[i] == 0);
          f.mchk = (k < int'(t_dur[i]));
          f.note = (k < int'(t_dur[i])) ? 4'(i) : (ending ? 4'd15 : 4'(nxt));
          if (k == int'(t_dur[i]) && G > 0 && !ending) begin
            f.mute = 1'b1; f.mchk = 1;
          end
          exp_q.push_back(f);
        end
        if (ending) begin exp_done = 1; break; end
        for (int g = 0; g < G; g++) begin
          f.mute = 1'b1; f.mchk = 1; f.note = 4'(nxt);
          exp_q.push_back(f);
        end
        i = nxt;
      end
    end
  endtask

  task automatic do_frame(input frame_t f, input string tag);
    int w;
    w = $urandom_range(2, 4);
    repeat (w) begin
      step();
      chk({tag, "_no_valid"}, sample_valid, 1'b0);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk({tag, "_valid"}, sample_valid, 1'b1);
    chk({tag, "_index"}, sample_index, f.idx);
    chk({tag, "_note"}, note_idx, f.note);
    if (f.mchk) chk({tag, "_mute"}, mute, f.mute);
  endtask

  task automatic run_seq(input string tag, input bit lp, input int maxf);
    bit exp_done;
    frame_t f;
    build_model(lp, maxf, exp_done);
    loop_en = lp;
    done_cnt = 0; fall_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1'b1);
    while (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      do_frame(f, tag);
      if (tag == "single") begin
        // A start request while busy must not restart the sequence.
        start = 1'b1; step(); start = 1'b0;
      end
    end
    if (exp_done) begin
      for (int c = 0; c < 20 && busy; c++) step();
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_at_fall"}, fall_done, 1'b1);
      chk({tag, "_mute_idle"}, mute, 1'b1);
    end else begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk({tag, "_stop_busy"}, busy, 1'b0);
      chk({tag, "_stop_note"}, note_idx, 4'd0);
      chk({tag, "_stop_index"}, sample_index, 6'd0);
      chk({tag, "_no_done"}, done_cnt, 0);
    end
    step();
  endtask

  task automatic clear_table();
    for (int a = 0; a < 16; a++) begin
      t_inc[a] = 16'($urandom); t_dur[a] = 16'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    bit lp;
    reset_n = 1'b0; ready = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; cfg_addr = '0; cfg_phase_inc = '0; cfg_duration = '0;
    done_cnt = 0; fall_done = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_note", note_idx, 4'd0);
    chk("rst_index", sample_index, 6'd0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_mute", mute, 1'b1);
    reset_n = 1'b1;
    step();

    // Single note of three frames, then end marker.
    clear_table();
    t_inc[0] = 16'h0400; t_dur[0] = 16'd3;
    program_table();
    run_seq("single", 1'b0, 1000);

    // Rest note: silent, index stays at zero.
    clear_table();
    t_inc[0] = 16'h0000; t_dur[0] = 16'd2;
    program_table();
    run_seq("rest", 1'b0, 1000);

    // Accumulator wrap: 63 then 62.
    clear_table();
    t_inc[0] = 16'hFC00; t_dur[0] = 16'd2;
    program_table();
    run_seq("wrap", 1'b0, 1000);

    // Two notes; GAP frames appear between them only when compiled in.
    clear_table();
    t_inc[0] = 16'h1000; t_dur[0] = 16'd2;
    t_inc[1] = 16'h2000; t_dur[1] = 16'd2;
    program_table();
    run_seq("two_notes", 1'b0, 1000);

    // Full table, one frame each: loop wraps past entry 15, no-loop finishes.
    for (int a = 0; a < 16; a++) begin
      t_inc[a] = 16'(($urandom_range(1, 255)) << 8); t_dur[a] = 16'd1;
    end
    program_table();
    run_seq("loop16", 1'b1, 17 * (1 + G));
    run_seq("end16", 1'b0, 1000);

    // Stop together with ready mid-note.
    clear_table();
    t_inc[0] = 16'h0400; t_dur[0] = 16'd5;
    program_table();
    loop_en = 1'b0; done_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (2) begin
      repeat (2) step();
      ready = 1'b1; step(); ready = 1'b0;
    end
    chk("pre_stop_index", sample_index, 6'd2);
    step();
    stop = 1'b1; ready = 1'b1;
    step();
    stop = 1'b0; ready = 1'b0;
    chk("stop_valid", sample_valid, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    chk("stop_index", sample_index, 6'd0);
    chk("stop_note", note_idx, 4'd0);
    chk("stop_mute", mute, 1'b1);
    repeat (3) step();
    chk("stop_no_done", done_cnt, 0);

    // Randomized tables and loop setting.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++) begin
        t_inc[a] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        t_dur[a] = 16'($urandom_range(1, 3));
      end
      e = $urandom_range(1, 16);
      if (e < 16) t_dur[e] = 16'd0;
      lp = 1'($urandom_range(0, 1));
      program_table();
      run_seq("random", lp, 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a programmed note sequence through the 64-entry sine sample table by stepping its index once per codec frame. Sits between the codec frame strobe (`ready`) and the sine sample lookup: owns a phase accumulator, a 16-entry note table (phase increment and duration per note) and the play/stop state machine. Downstream logic converts `sample_index` to a 20-bit PCM sample and forces silence while `mute` is high.

## Interface
- `NOTES`, 16: note table depth. Power of two; address width `AW = log2(NOTES)`.
- `PHASE_W`, 16: phase accumulator and phase increment width. Must be at least 6.
- `DUR_W`, 16: note duration width, in codec frames.
- `GAP_FRAMES`, 4: inter-note silence length in frames. Used only with `TONE_SEQ_GAP_EN`; must be at least 1.

Ports:
- `clock_24M` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ready` in 1: codec frame strobe, one-cycle pulse per sample frame.
- `cfg_we` in 1: note table write enable.
- `cfg_addr` in AW: note table write address.
- `cfg_phase_inc` in PHASE_W: phase increment for the written entry. 0 means a rest.
- `cfg_duration` in DUR_W: frames for the written entry. 0 marks end of sequence.
- `start` in 1: level-sampled start request.
- `stop` in 1: level-sampled abort request.
- `loop_en` in 1: restart from entry 0 at end of sequence instead of finishing.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on normal sequence completion.
- `note_idx` out AW: current table entry.
- `sample_index` out 6: `acc[PHASE_W-1 -: 6]`.
- `sample_valid` out 1: one-cycle pulse when `sample_index` holds a new frame value.
- `mute` out 1: high when the output must be silent.

## Operation
- States: IDLE, LOAD, PLAY, GAP (GAP exists only with the macro).
- IDLE: `mute`=1. `start`=1 with `stop`=0 → LOAD, with `note_idx`=0.
- LOAD, 1 cycle. Reads entry `note_idx`.
  - duration≠0: `frames_left`=duration, `acc`=0 → PLAY.
  - duration=0 and `loop_en`=1 and `note_idx`≠0: `note_idx`=0 → LOAD.
  - Otherwise: pulse `done` → IDLE.
- PLAY: `mute`=1 if phase_inc=0, else 0. On each `ready`:
  - `acc` += phase_inc, modulo 2^PHASE_W (wrap-around is the intended periodic behaviour).
  - `frames_left` -= 1.
  - When `frames_left` reaches 0, advance the note:
    - If `note_idx`=NOTES-1: wrap to 0 when `loop_en`=1, otherwise pulse `done` → IDLE.
    - Otherwise `note_idx`+1 → GAP if compiled in, else LOAD.
- GAP: `mute`=1 and `acc` is held. Counts GAP_FRAMES `ready` pulses, then → LOAD.
- `stop`=1 in any state → IDLE next cycle. `done` is not pulsed; `note_idx` and `acc` are cleared.
- `stop` has priority over `start` and over a simultaneous `ready`.
- `start` while busy is ignored.
- `cfg_we` is accepted in any state. LOAD reads the table contents as they stood at the start of the LOAD cycle; a same-cycle write to the same address is seen on the next visit.
- `loop_en` is sampled only at end-of-sequence decisions.

## Timing
- Reset values: `busy` 0, `done` 0, `note_idx` 0, `sample_index` 0, `sample_valid` 0, `mute` 1, state IDLE.
- `start` sampled at edge N: LOAD at N+1, PLAY at N+2.
- `ready` sampled in PLAY or GAP at edge N: updated `sample_index` and a 1-cycle `sample_valid` at N+1.
- A `ready` that arrives in IDLE or LOAD is dropped. No frame is buffered.
- Last frame of a note: its `sample_valid` and the state change to GAP/LOAD occur on the same edge.
- `done` is registered: high for exactly one cycle, in the cycle `busy` falls.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `TONE_SEQ_GAP_EN` defined: GAP state inserted between consecutive notes, including the loop wrap. `mute`=1 for GAP_FRAMES frames, and `sample_valid` still pulses each frame.
- Not defined: PLAY goes directly to LOAD, and consecutive notes are separated only by the 1-cycle LOAD. GAP logic and `GAP_FRAMES` are unused.

## Test plan
- Entry 0 = {0x0400, 3}, entry 1 = {x, 0}; start, then 3 `ready` pulses → `sample_index` 1, 2, 3, each with `sample_valid` one cycle after `ready`. Then LOAD of entry 1, then `done` pulses and `busy`=0.
- Entry 0 = {0x0000, 2} (rest) → `mute`=1 throughout, `sample_index` stays 0, 2 `sample_valid` pulses.
- All 16 entries duration 1, `loop_en`=1 → after entry 15, `note_idx` wraps to 0 and `done` never pulses. Repeat with `loop_en`=0 → `done` pulses after entry 15.
- `stop` asserted mid-PLAY together with `ready` → next cycle IDLE, no `sample_valid`, no `done`, `sample_index` 0.
- Phase increment 0xFC00 for 2 frames → `sample_index` 63 then 62 (accumulator wrap).
- With `TONE_SEQ_GAP_EN`, GAP_FRAMES=4 and two 2-frame notes → 4 muted `sample_valid` pulses between the notes. Without the macro → none.
